// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - controller states, SSD1306 command codes and init sequence length
package ssd1306_pkg;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    INIT,
    IDLE,
    SHIFT,
    GAP
  } state_e;

  localparam logic [7:0] CMD_DISPLAY_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'hAF;
  localparam logic [7:0] CMD_SET_CLK_DIV  = 8'hD5;
  localparam logic [7:0] CMD_SET_MUX      = 8'hA8;
  localparam logic [7:0] CMD_SET_OFFSET   = 8'hD3;
  localparam logic [7:0] CMD_START_LINE   = 8'h40;
  localparam logic [7:0] CMD_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] CMD_MEM_MODE     = 8'h20;
  localparam logic [7:0] CMD_SEG_REMAP    = 8'hA1;
  localparam logic [7:0] CMD_COM_SCAN_DEC = 8'hC8;
  localparam logic [7:0] CMD_COM_PINS     = 8'hDA;
  localparam logic [7:0] CMD_CONTRAST     = 8'h81;
  localparam logic [7:0] CMD_PRECHARGE    = 8'hD9;
  localparam logic [7:0] CMD_VCOMH        = 8'hDB;
  localparam logic [7:0] CMD_RESUME_RAM   = 8'hA4;
  localparam logic [7:0] CMD_NORMAL       = 8'hA6;
  localparam logic [7:0] CMD_NOP          = 8'hE3;

  localparam int INIT_LEN   = 25;
  localparam int INIT_IDX_W = $clog2(INIT_LEN);

endpackage

// File: rtl/ssd1306_init_rom.sv
// rtl/ssd1306_init_rom.sv - power-up command sequence lookup (used with SSD1306_INIT_ROM_EN)
import ssd1306_pkg::*;

module ssd1306_init_rom (
  input  logic [INIT_IDX_W-1:0] idx_i,
  output logic [7:0]            byte_o
);

  // Index to command byte; unused indices return a harmless NOP
  always_comb begin
    byte_o = CMD_NOP;
    case (idx_i)
      5'd0:  byte_o = CMD_DISPLAY_OFF;
      5'd1:  byte_o = CMD_SET_CLK_DIV;
      5'd2:  byte_o = 8'h80;
      5'd3:  byte_o = CMD_SET_MUX;
      5'd4:  byte_o = 8'h3F;
      5'd5:  byte_o = CMD_SET_OFFSET;
      5'd6:  byte_o = 8'h00;
      5'd7:  byte_o = CMD_START_LINE;
      5'd8:  byte_o = CMD_CHARGE_PUMP;
      5'd9:  byte_o = 8'h14;
      5'd10: byte_o = CMD_MEM_MODE;
      5'd11: byte_o = 8'h00;
      5'd12: byte_o = CMD_SEG_REMAP;
      5'd13: byte_o = CMD_COM_SCAN_DEC;
      5'd14: byte_o = CMD_COM_PINS;
      5'd15: byte_o = 8'h12;
      5'd16: byte_o = CMD_CONTRAST;
      5'd17: byte_o = 8'hCF;
      5'd18: byte_o = CMD_PRECHARGE;
      5'd19: byte_o = 8'hF1;
      5'd20: byte_o = CMD_VCOMH;
      5'd21: byte_o = 8'h40;
      5'd22: byte_o = CMD_RESUME_RAM;
      5'd23: byte_o = CMD_NORMAL;
      5'd24: byte_o = CMD_DISPLAY_ON;
      default: byte_o = CMD_NOP;
    endcase
  end

endmodule

// File: rtl/ssd1306_spi4_ctrl.sv
// rtl/ssd1306_spi4_ctrl.sv - SSD1306 4-wire SPI master with panel reset; optional init ROM via SSD1306_INIT_ROM_EN
import ssd1306_pkg::*;

module ssd1306_spi4_ctrl #(
  parameter int CLK_DIV       = 4,
  parameter int RST_PULSE_CYC = 1000,
  parameter int RST_WAIT_CYC  = 1000,
  parameter int CS_GAP        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_dc,
  output logic       busy,
  output logic       init_done,
  output logic       oled_rst_n,
  output logic       oled_cs_n,
  output logic       oled_dc,
  output logic       oled_clk,
  output logic       oled_data
);

  localparam int MAX_A   = (RST_PULSE_CYC > RST_WAIT_CYC) ? RST_PULSE_CYC : RST_WAIT_CYC;
  localparam int MAX_B   = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             dc_q, dc_d;
  logic             init_done_q, init_done_d;
  logic             rst_n_q, rst_n_d;
  logic             cs_n_q, cs_n_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

`ifdef SSD1306_INIT_ROM_EN
  logic [INIT_IDX_W-1:0] rom_idx_q, rom_idx_d;
  logic [7:0]            rom_byte;

  ssd1306_init_rom u_rom (
    .idx_i  (rom_idx_q),
    .byte_o (rom_byte)
  );
`endif

  // Next-state logic; the cycle counter is cleared on every state entry
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    shreg_d     = shreg_q;
    dc_d        = dc_q;
    init_done_d = init_done_q;
`ifdef SSD1306_INIT_ROM_EN
    rom_idx_d   = rom_idx_q;
`endif
    unique case (state_q)
      RST_LOW: begin
        if (cnt_q == CNT_W'(RST_PULSE_CYC - 1)) begin
          state_d = RST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RST_WAIT: begin
        if (cnt_q == CNT_W'(RST_WAIT_CYC - 1)) begin
          cnt_d = '0;
`ifdef SSD1306_INIT_ROM_EN
          state_d   = INIT;
          rom_idx_d = '0;
`else
          state_d     = IDLE;
          init_done_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      INIT: begin
`ifdef SSD1306_INIT_ROM_EN
        shreg_d = rom_byte;
        dc_d    = 1'b0;
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        if (s_valid && ready_q) begin
          shreg_d = s_data;
          dc_d    = s_dc;
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[6:0], 1'b0};
            if (bit_q == 3'd7) begin
              state_d = GAP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef SSD1306_INIT_ROM_EN
          if (!init_done_q) begin
            if (rom_idx_q == INIT_IDX_W'(INIT_LEN - 1)) begin
              init_done_d = 1'b1;
            end else begin
              rom_idx_d = rom_idx_q + INIT_IDX_W'(1);
              state_d   = INIT;
            end
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RST_LOW;
    endcase

    rst_n_d = (state_d != RST_LOW);
    cs_n_d  = (state_d != SHIFT);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset aborts any byte and restarts the panel reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_LOW;
      cnt_q       <= '0;
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      shreg_q     <= '0;
      dc_q        <= 1'b0;
      init_done_q <= 1'b0;
      rst_n_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
`ifdef SSD1306_INIT_ROM_EN
      rom_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      shreg_q     <= shreg_d;
      dc_q        <= dc_d;
      init_done_q <= init_done_d;
      rst_n_q     <= rst_n_d;
      cs_n_q      <= cs_n_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
`ifdef SSD1306_INIT_ROM_EN
      rom_idx_q   <= rom_idx_d;
`endif
    end
  end

  assign s_ready    = ready_q;
  assign busy       = busy_q;
  assign init_done  = init_done_q;
  assign oled_rst_n = rst_n_q;
  assign oled_cs_n  = cs_n_q;
  assign oled_dc    = dc_q;
  assign oled_clk   = sclk_q;
  assign oled_data  = shreg_q[7];

endmodule

// File: tb/tb_ssd1306_spi4_ctrl.sv
// tb/tb_ssd1306_spi4_ctrl.sv - self-checking bench for ssd1306_spi4_ctrl (SSD1306_INIT_ROM_EN aware)
module tb_ssd1306_spi4_ctrl;

  localparam int CLK_DIV       = 2;
  localparam int RST_PULSE_CYC = 10;
  localparam int RST_WAIT_CYC  = 20;
  localparam int CS_GAP        = 2;
  localparam int BYTE_CYC      = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_dc = 1'b0;
  logic       s_ready, busy, init_done;
  logic       oled_rst_n, oled_cs_n, oled_dc, oled_clk, oled_data;

  ssd1306_spi4_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .RST_PULSE_CYC (RST_PULSE_CYC),
    .RST_WAIT_CYC  (RST_WAIT_CYC),
    .CS_GAP        (CS_GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_dc       (s_dc),
    .busy       (busy),
    .init_done  (init_done),
    .oled_rst_n (oled_rst_n),
    .oled_cs_n  (oled_cs_n),
    .oled_dc    (oled_dc),
    .oled_clk   (oled_clk),
    .oled_data  (oled_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       dc;
    int         nb;
    int         len;
  } win_t;

  win_t rx_q[$];
  win_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  logic       prev_sclk = 1'b0;
  bit         in_win = 1'b0;
  logic [7:0] mon_sh = 8'h00;
  logic       mon_dc = 1'b0;
  int         mon_nb = 0;
  int         mon_len = 0;

`ifdef SSD1306_INIT_ROM_EN
  logic [7:0] rom_tab [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                               8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                               8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
`endif

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Panel-side capture: one entry per CS-low window, bits taken on SCLK rises
  initial forever begin
    @(negedge clk);
    if (oled_cs_n === 1'b0) begin
      if (!in_win) begin
        in_win = 1'b1; mon_sh = 8'h00; mon_nb = 0; mon_len = 0;
      end
      mon_len++;
      mon_dc = oled_dc;
      if (oled_clk === 1'b1 && prev_sclk === 1'b0) begin
        mon_sh = {mon_sh[6:0], oled_data};
        mon_nb++;
      end
    end else if (in_win) begin
      in_win = 1'b0;
      rx_q.push_back('{b: mon_sh, dc: mon_dc, nb: mon_nb, len: mon_len});
    end
    prev_sclk = oled_clk;
  end

  task automatic release_and_check(input string tag);
    int n;
    bit cs_ok;
    cs_ok = 1'b1;
    rst = 1'b0;
    n = 0;
    while (oled_rst_n === 1'b0 && n < 500) begin
      if (oled_cs_n !== 1'b1) cs_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    n_checks++; if (n != RST_PULSE_CYC) $display("FAIL %s_rst_pulse got %0d cycles want %0d", tag, n, RST_PULSE_CYC); else n_pass++;
`ifdef SSD1306_INIT_ROM_EN
    begin
      bit rdy_ok;
      win_t w;
      rdy_ok = 1'b1;
      for (int i = 0; i < 25; i++) exp_q.push_back('{b: rom_tab[i], dc: 1'b0, nb: 8, len: BYTE_CYC});
      n = 0;
      while (init_done !== 1'b1 && n < 3000) begin
        if (s_ready !== 1'b0) rdy_ok = 1'b0;
        n++;
        @(negedge clk);
      end
      n_checks++; if (init_done !== 1'b1) $display("FAIL %s_init_done got %b want 1", tag, init_done); else n_pass++;
      n_checks++; if (!rdy_ok) $display("FAIL %s_ready_during_init got 1 want 0", tag); else n_pass++;
      n_checks++; if (s_ready !== 1'b1) $display("FAIL %s_ready_after_init got %b want 1", tag, s_ready); else n_pass++;
      for (int i = 0; i < 25; i++) begin
        n_checks++;
        if (rx_q.size() == 0) $display("FAIL %s_rom_byte%0d got none want %h", tag, i, rom_tab[i]);
        else begin
          win_t e;
          w = rx_q.pop_front(); e = exp_q.pop_front();
          if (w.b !== e.b || w.dc !== e.dc || w.nb != 8) $display("FAIL %s_rom_byte%0d got %h/dc%b/%0d bits want %h/dc0/8", tag, i, w.b, w.dc, w.nb, e.b);
          else n_pass++;
        end
      end
      exp_q.delete();
    end
`else
    n = 0;
    while (s_ready !== 1'b1 && n < 500) begin
      if (oled_cs_n !== 1'b1) cs_ok = 1'b0;
      if (init_done !== 1'b0) cs_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    n_checks++; if (n != RST_WAIT_CYC) $display("FAIL %s_rst_wait got %0d cycles want %0d", tag, n, RST_WAIT_CYC); else n_pass++;
    n_checks++; if (init_done !== 1'b1) $display("FAIL %s_init_done got %b want 1", tag, init_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL %s_busy_idle got %b want 0", tag, busy); else n_pass++;
`endif
    n_checks++; if (!cs_ok) $display("FAIL %s_cs_during_reset got active want idle", tag); else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (oled_rst_n !== 1'b0) $display("FAIL reset_rst_n got %b want 0", oled_rst_n); else n_pass++;
    n_checks++; if (oled_cs_n !== 1'b1) $display("FAIL reset_cs_n got %b want 1", oled_cs_n); else n_pass++;
    n_checks++; if (oled_dc !== 1'b0) $display("FAIL reset_dc got %b want 0", oled_dc); else n_pass++;
    n_checks++; if (oled_clk !== 1'b0) $display("FAIL reset_sclk got %b want 0", oled_clk); else n_pass++;
    n_checks++; if (oled_data !== 1'b0) $display("FAIL reset_mosi got %b want 0", oled_data); else n_pass++;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", s_ready); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else n_pass++;
    n_checks++; if (init_done !== 1'b0) $display("FAIL reset_init_done got %b want 0", init_done); else n_pass++;
    release_and_check("reset");
  endtask

  task automatic test_single();
    int n;
    win_t w, e;
    exp_q.push_back('{b: 8'hA5, dc: 1'b0, nb: 8, len: BYTE_CYC});
    s_data = 8'hA5; s_dc = 1'b0; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL single_ready_drop got %b want 0", s_ready); else n_pass++;
    n_checks++; if (oled_cs_n !== 1'b0) $display("FAIL single_cs_low got %b want 0", oled_cs_n); else n_pass++;
    n_checks++; if (oled_data !== 1'b1 || oled_dc !== 1'b0) $display("FAIL single_first_bit got data%b dc%b want data1 dc0", oled_data, oled_dc); else n_pass++;
    repeat (CLK_DIV - 1) @(negedge clk);
    n_checks++; if (oled_clk !== 1'b0) $display("FAIL single_sclk_low got %b want 0", oled_clk); else n_pass++;
    @(negedge clk);
    n_checks++; if (oled_clk !== 1'b1) $display("FAIL single_sclk_rise got %b want 1", oled_clk); else n_pass++;
    n = CLK_DIV;
    while (oled_cs_n === 1'b0 && n < 200) begin n++; @(negedge clk); end
    n_checks++; if (n != BYTE_CYC) $display("FAIL single_cs_len got %0d want %0d", n, BYTE_CYC); else n_pass++;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    n_checks++; if (n != CS_GAP) $display("FAIL single_gap got %0d want %0d", n, CS_GAP); else n_pass++;
    n_checks++;
    if (rx_q.size() == 0) $display("FAIL single_byte got none want a5");
    else begin
      w = rx_q.pop_front(); e = exp_q.pop_front();
      if (w.b !== e.b || w.dc !== e.dc || w.nb != e.nb || w.len != e.len)
        $display("FAIL single_byte got %h/dc%b/%0d bits/%0d cyc want %h/dc%b/%0d/%0d", w.b, w.dc, w.nb, w.len, e.b, e.dc, e.nb, e.len);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n, t0, t1;
    win_t w, e;
    s_valid = 1'b1; s_data = 8'hFF; s_dc = 1'b1;
    exp_q.push_back('{b: 8'hFF, dc: 1'b1, nb: 8, len: BYTE_CYC});
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    t0 = cyc;
    @(negedge clk);
    s_data = 8'h00;
    exp_q.push_back('{b: 8'h00, dc: 1'b1, nb: 8, len: BYTE_CYC});
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    t1 = cyc;
    @(negedge clk);
    s_valid = 1'b0;
    n_checks++; if (t1 - t0 != BYTE_CYC + CS_GAP + 1) $display("FAIL b2b_spacing got %0d want %0d", t1 - t0, BYTE_CYC + CS_GAP + 1); else n_pass++;
    n = 0;
    while ((rx_q.size() < 2 || s_ready !== 1'b1) && n < 200) begin n++; @(negedge clk); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rx_q.size() == 0 || exp_q.size() == 0) $display("FAIL b2b_byte%0d got none want a byte", i);
      else begin
        w = rx_q.pop_front(); e = exp_q.pop_front();
        if (w.b !== e.b || w.dc !== e.dc || w.nb != e.nb || w.len != e.len)
          $display("FAIL b2b_byte%0d got %h/dc%b/%0d bits/%0d cyc want %h/dc%b/%0d/%0d", i, w.b, w.dc, w.nb, w.len, e.b, e.dc, e.nb, e.len);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    win_t w, e;
    s_valid = 1'b1; s_data = 8'h3C; s_dc = 1'b0;
    exp_q.push_back('{b: 8'h3C, dc: 1'b0, nb: 8, len: BYTE_CYC});
    @(negedge clk);
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      s_data = 8'($urandom_range(0, 255));
      s_dc = 1'($urandom_range(0, 1));
      n++;
      @(negedge clk);
    end
    exp_q.push_back('{b: s_data, dc: s_dc, nb: 8, len: BYTE_CYC});
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while ((rx_q.size() < 2 || s_ready !== 1'b1) && n < 200) begin n++; @(negedge clk); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rx_q.size() == 0 || exp_q.size() == 0) $display("FAIL bp_byte%0d got none want a byte", i);
      else begin
        w = rx_q.pop_front(); e = exp_q.pop_front();
        if (w.b !== e.b || w.dc !== e.dc || w.nb != e.nb || w.len != e.len)
          $display("FAIL bp_byte%0d got %h/dc%b/%0d bits/%0d cyc want %h/dc%b/%0d/%0d", i, w.b, w.dc, w.nb, w.len, e.b, e.dc, e.nb, e.len);
        else n_pass++;
      end
    end
    repeat (60) @(negedge clk);
    n_checks++; if (rx_q.size() != 0) $display("FAIL bp_extra_bytes got %0d want 0", rx_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    win_t w;
    s_valid = 1'b1; s_data = 8'hC3; s_dc = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (mon_nb < 3 && n < 200) begin n++; @(negedge clk); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (oled_cs_n !== 1'b1) $display("FAIL mid_cs_n got %b want 1", oled_cs_n); else n_pass++;
    n_checks++; if (oled_rst_n !== 1'b0) $display("FAIL mid_rst_n got %b want 0", oled_rst_n); else n_pass++;
    n_checks++; if (s_ready !== 1'b0 || busy !== 1'b1) $display("FAIL mid_ready_busy got %b%b want 01", s_ready, busy); else n_pass++;
    n_checks++; if (oled_clk !== 1'b0 || oled_data !== 1'b0 || oled_dc !== 1'b0) $display("FAIL mid_pins got sclk%b mosi%b dc%b want 000", oled_clk, oled_data, oled_dc); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rx_q.size() == 0) $display("FAIL mid_partial got none want 3-bit window");
    else begin
      w = rx_q.pop_front();
      if (w.nb != 3 || w.b[2:0] !== 3'b110) $display("FAIL mid_partial got %0d bits %b want 3 bits 110", w.nb, w.b[2:0]);
      else n_pass++;
    end
    release_and_check("mid");
    repeat (100) @(negedge clk);
    n_checks++; if (rx_q.size() != 0) $display("FAIL mid_resumed got %0d windows want 0", rx_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
